// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core data-memory path.
package riscv_pkg;

   localparam int XLEN = 32;

   // funct3 encodings for loads/stores (size and signedness)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Memory-stage sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the memory stage.
// Request side: byte enables, lane-shifted store data and a fault flag
// covering both misalignment and undefined encodings.
// Response side: lane extraction with sign/zero extension.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [3:0]      req_op,       // {is_store, funct3}
   input  logic [1:0]      req_lane,     // addr[1:0]
   input  logic [XLEN-1:0] req_wdata,
   output logic [3:0]      req_be,
   output logic [XLEN-1:0] req_wdata_sh,
   output logic            req_fault,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_lane,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] lane_word;

   // Request decode: unsigned variants exist only for loads
   always_comb begin
      req_be       = 4'b0000;
      req_fault    = 1'b0;
      req_wdata_sh = req_wdata << {req_lane, 3'b000};
      case (req_op[2:0])
         F3_B: req_be = 4'b0001 << req_lane;
         F3_H: begin
            req_be    = 4'b0011 << req_lane;
            req_fault = req_lane[0];
         end
         F3_W: begin
            req_be    = 4'b1111;
            req_fault = |req_lane;
         end
         F3_BU: begin
            req_be    = 4'b0001 << req_lane;
            req_fault = req_op[3];
         end
         F3_HU: begin
            req_be    = 4'b0011 << req_lane;
            req_fault = req_op[3] | req_lane[0];
         end
         default: req_fault = 1'b1;
      endcase
   end

   // Response: move the addressed lane down to bit 0, then extend
   always_comb begin
      lane_word = ld_rdata >> {ld_lane, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{(XLEN-8){lane_word[7]}}, lane_word[7:0]};
         F3_BU:   ld_data = {{(XLEN-8){1'b0}}, lane_word[7:0]};
         F3_H:    ld_data = {{(XLEN-16){lane_word[15]}}, lane_word[15:0]};
         F3_HU:   ld_data = {{(XLEN-16){1'b0}}, lane_word[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Data-memory access stage: one load/store in flight between execute
// and writeback, with traps for misaligned/illegal accesses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. in_valid/in_ready (execute side), dmem_req/dmem_gnt
// (memory side) and wb_valid/wb_ready (writeback side) all follow this;
// a producer holds valid and its payload stable until the transfer.
// dmem_rvalid is a one-cycle strobe with no ready.
module mem_stage #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [RD_W-1:0] in_rd,
   output logic            dmem_req,
   input  logic            dmem_gnt,
   output logic            dmem_we,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            err,
   output logic [XLEN-1:0] err_addr
);

   import riscv_pkg::*;

   state_t          state;
   logic [2:0]      funct3_q;
   logic [1:0]      lane_q;
   logic [3:0]      req_be;
   logic [XLEN-1:0] req_wdata_sh;
   logic            req_fault;
   logic [XLEN-1:0] ld_data;

   lsu_align u_align (
      .req_op       (in_op),
      .req_lane     (in_addr[1:0]),
      .req_wdata    (in_wdata),
      .req_be       (req_be),
      .req_wdata_sh (req_wdata_sh),
      .req_fault    (req_fault),
      .ld_funct3    (funct3_q),
      .ld_lane      (lane_q),
      .ld_rdata     (dmem_rdata),
      .ld_data      (ld_data)
   );

   // Status outputs decode directly from the state register
   assign in_ready = (state == ST_IDLE);
   assign dmem_req = (state == ST_ISSUE);
   assign wb_valid = (state == ST_RESP);
   assign err      = (state == ST_ERR);

   // Sequencer plus request/response registers; reset abandons any access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         funct3_q   <= 3'b000;
         lane_q     <= 2'b00;
         dmem_we    <= 1'b0;
         dmem_be    <= 4'b0000;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_rd      <= '0;
         wb_data    <= '0;
         err_addr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (req_fault) begin
                     err_addr <= in_addr;
                     state    <= ST_ERR;
                  end else begin
                     funct3_q   <= in_op[2:0];
                     lane_q     <= in_addr[1:0];
                     wb_rd      <= in_rd;
                     dmem_we    <= in_op[3];
                     dmem_be    <= req_be;
                     dmem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                     dmem_wdata <= req_wdata_sh;
                     state      <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (dmem_gnt) state <= dmem_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  wb_data <= ld_data;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (wb_ready) state <= ST_IDLE;
            end
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
